// File: rtl/ibn_pkg.sv
// Shared constants for the ibnalhaytham Wishbone loader: register offsets,
// CTRL/STATUS field positions and the bus FSM state encoding.
// Optional feature macro: IBN_WB_READBACK_EN adds the memory read-back states.
package ibn_pkg;

  // Byte offsets inside the 256-byte register window
  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_ADDR   = 8'h04;
  localparam logic [7:0] OFS_DATA   = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;
  localparam logic [7:0] OFS_PC     = 8'h10;

  // CTRL fields
  localparam int CTRL_HOLD = 0;
  localparam int CTRL_CRST = 1;

  // STATUS fields (count lives in [3:0])
  localparam int STAT_BUSY = 4;
  localparam int STAT_HOLD = 5;
  localparam int STAT_ERR  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_WSTALL
`ifdef IBN_WB_READBACK_EN
    ,
    ST_RDRAIN,
    ST_RREQ,
    ST_RWAIT
`endif
  } bus_state_t;

endpackage

// File: rtl/ibn_wb_fifo.sv
// Synchronous write buffer holding {word address, data} entries for the loader.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push is ignored when full, pop ignored when empty; count is registered.
// Ports: clk/rst, push/push_dat, pop/head_dat, count/full/empty.
module ibn_wb_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: reset empties the FIFO through the pointers/count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/ibn_wb_loader.sv
// Wishbone responder that loads and controls the ibnalhaytham core (CTRL/ADDR/DATA/STATUS/PC).
// Latency: register access acks 1 cycle after sampling; DATA writes drain to imem via req/gnt.
// Backpressure: DATA write to a full buffer withholds ack until space; imem req held until gnt.
// Ports: wb_clk_i/wb_rst_i, wbs_* classic Wishbone slave, imem_* req/gnt memory port,
//   core_pc_i, core_hold_o/core_rst_o. Macro IBN_WB_READBACK_EN enables DATA read-back.
module ibn_wb_loader
  import ibn_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          IMEM_AW    = 10,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               imem_req_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  input  logic               imem_gnt_i,
  input  logic [31:0]        imem_rdata_i,
  input  logic               imem_rvalid_i,
  input  logic [31:0]        core_pc_i,
  output logic               core_hold_o,
  output logic               core_rst_o
);

  localparam int                 CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int                 ENT_W    = IMEM_AW + 32;
  localparam logic [IMEM_AW-1:0] ADDR_ONE = IMEM_AW'(1);

  bus_state_t         state_q, state_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic               hold_q, hold_d;
  logic               crst_q, crst_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic               err_q, err_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] maddr_q, maddr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               push, pop;
  logic [ENT_W-1:0]   fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;

  logic               bus_act, in_win, is_data;
  logic [7:0]         ofs;
  logic [31:0]        rd_mux;
  logic               issue_rd, drain_ok;

  assign bus_act = wbs_stb_i && wbs_cyc_i;
  assign in_win  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign ofs     = wbs_adr_i[7:0];
  assign is_data = in_win && (ofs == OFS_DATA);

`ifdef IBN_WB_READBACK_EN
  logic rabort_q, rabort_d;  // bus dropped after the read was issued: finish it silently

  assign issue_rd = (state_q == ST_RREQ) && !req_q && bus_act;
  assign drain_ok = (state_q != ST_RREQ);
`else
  logic unused_readback;
  assign unused_readback = ^{imem_rdata_i, imem_rvalid_i};
  assign issue_rd = 1'b0;
  assign drain_ok = 1'b1;
`endif

  ibn_wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push     (push),
    .push_dat ({addr_q, wbs_dat_i}),
    .pop      (pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Read data for simple register reads; DATA and unmapped offsets return 0.
  always_comb begin
    rd_mux = '0;
    if (in_win) begin
      case (ofs)
        OFS_CTRL: begin
          rd_mux[CTRL_HOLD] = hold_q;
          rd_mux[CTRL_CRST] = crst_q;
        end
        OFS_ADDR: rd_mux[IMEM_AW-1:0] = addr_q;
        OFS_STATUS: begin
          rd_mux[3:0]       = 4'(fifo_count);
          rd_mux[STAT_BUSY] = !fifo_empty;
          rd_mux[STAT_HOLD] = hold_q;
          rd_mux[STAT_ERR]  = err_q;
        end
        OFS_PC:  rd_mux = core_pc_i;
        default: rd_mux = '0;
      endcase
    end
  end

  // Bus FSM and register file
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    hold_d  = hold_q;
    crst_d  = crst_q;
    addr_d  = addr_q;
    err_d   = err_q;
    push    = 1'b0;
`ifdef IBN_WB_READBACK_EN
    rabort_d = rabort_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus_act && !ack_q) begin
          if (is_data && wbs_we_i) begin
            if (wbs_sel_i != 4'hF) begin
              err_d   = 1'b1;
              ack_d   = 1'b1;
              state_d = ST_ACK;
            end else if (fifo_full) begin
              state_d = ST_WSTALL;
            end else begin
              push    = 1'b1;
              addr_d  = addr_q + ADDR_ONE;
              ack_d   = 1'b1;
              state_d = ST_ACK;
            end
          end
`ifdef IBN_WB_READBACK_EN
          else if (is_data) begin
            state_d = ST_RDRAIN;
          end
`endif
          else begin
            ack_d   = 1'b1;
            state_d = ST_ACK;
            if (!wbs_we_i) begin
              dat_d = rd_mux;
            end else if (in_win) begin
              case (ofs)
                OFS_CTRL: begin
                  if (wbs_sel_i[0]) begin
                    hold_d = wbs_dat_i[CTRL_HOLD];
                    crst_d = wbs_dat_i[CTRL_CRST];
                  end
                end
                OFS_ADDR: begin
                  for (int i = 0; i < IMEM_AW; i++) begin
                    if (wbs_sel_i[i/8]) addr_d[i] = wbs_dat_i[i];
                  end
                end
                OFS_STATUS: begin
                  if (wbs_sel_i[1] && wbs_dat_i[STAT_ERR]) err_d = 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
      end
      ST_ACK: state_d = ST_IDLE;
      ST_WSTALL: begin
        // Space is judged on the registered count, so a same-cycle pop does not count.
        if (!bus_act) begin
          state_d = ST_IDLE;
        end else if (!fifo_full) begin
          push    = 1'b1;
          addr_d  = addr_q + ADDR_ONE;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
`ifdef IBN_WB_READBACK_EN
      ST_RDRAIN: begin
        if (!bus_act) state_d = ST_IDLE;
        else if (fifo_empty) state_d = ST_RREQ;
      end
      ST_RREQ: begin
        if (!req_q) begin
          if (!bus_act) state_d = ST_IDLE;
        end else begin
          if (!bus_act) rabort_d = 1'b1;
          if (imem_gnt_i) state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (!bus_act) rabort_d = 1'b1;
        if (imem_rvalid_i) begin
          rabort_d = 1'b0;
          if (rabort_q || !bus_act) begin
            state_d = ST_IDLE;
          end else begin
            ack_d   = 1'b1;
            dat_d   = imem_rdata_i;
            addr_d  = addr_q + ADDR_ONE;
            state_d = ST_ACK;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port. A request is loaded only when the port is idle and then held
  // until gnt, so the port drops for one cycle between transfers; this keeps
  // the head entry stable without looking ahead in the FIFO.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    pop     = 1'b0;
    if (req_q) begin
      if (imem_gnt_i) begin
        req_d = 1'b0;
        we_d  = 1'b0;
        pop   = we_q;
      end
    end else if (issue_rd) begin
      req_d   = 1'b1;
      we_d    = 1'b0;
      maddr_d = addr_q;
    end else if (drain_ok && !fifo_empty) begin
      req_d   = 1'b1;
      we_d    = 1'b1;
      maddr_d = fifo_head[ENT_W-1:32];
      wdata_d = fifo_head[31:0];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      hold_q   <= 1'b1;
      crst_q   <= 1'b1;
      addr_q   <= '0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      wdata_q  <= '0;
`ifdef IBN_WB_READBACK_EN
      rabort_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      hold_q   <= hold_d;
      crst_q   <= crst_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
`ifdef IBN_WB_READBACK_EN
      rabort_q <= rabort_d;
`endif
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign imem_req_o   = req_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = maddr_q;
  assign imem_wdata_o = wdata_q;
  assign core_hold_o  = hold_q;
  assign core_rst_o   = crst_q;

endmodule

// File: tb/tb_ibn_wb_loader.sv
// Directed bench for ibn_wb_loader: register access, buffered writes, full-buffer stall,
// partial-select error, reset mid-operation and (with IBN_WB_READBACK_EN) DATA read-back.
// Memory side is a gnt-controlled responder that logs every granted write.
module tb_ibn_wb_loader;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_ADDR   = 32'h3000_0004;
  localparam logic [31:0] A_DATA   = 32'h3000_0008;
  localparam logic [31:0] A_STATUS = 32'h3000_000C;
  localparam logic [31:0] A_PC     = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we_i = 1'b0;
  logic [3:0]  sel_i = 4'h0;
  logic [31:0] adr_i = '0, dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        imem_req_o, imem_we_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        gnt = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic [31:0] pc = '0;
  logic        core_hold_o, core_rst_o;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  logic [9:0]  wr_addr [64];
  logic [31:0] wr_data [64];

  ibn_wb_loader dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we_i),
    .wbs_sel_i     (sel_i),
    .wbs_adr_i     (adr_i),
    .wbs_dat_i     (dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .imem_req_o    (imem_req_o),
    .imem_we_o     (imem_we_o),
    .imem_addr_o   (imem_addr_o),
    .imem_wdata_o  (imem_wdata_o),
    .imem_gnt_i    (gnt),
    .imem_rdata_i  (rdata),
    .imem_rvalid_i (rvalid),
    .core_pc_i     (pc),
    .core_hold_o   (core_hold_o),
    .core_rst_o    (core_rst_o)
  );

  always #5 clk = ~clk;

  // Log every granted memory write
  always @(posedge clk) begin
    if (imem_req_o && gnt && imem_we_o) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] <= imem_addr_o;
        wr_data[wr_cnt] <= imem_wdata_o;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

`ifdef IBN_WB_READBACK_EN
  int         rd_cnt = 0;
  int         rd_after = 0;
  logic [9:0] rd_addr_seen = '0;
  // Read responder: rvalid two cycles after the granted read
  initial begin
    forever begin
      @(posedge clk);
      if (imem_req_o && gnt && !imem_we_o) begin
        rd_cnt++;
        rd_after = wr_cnt;
        rd_addr_seen = imem_addr_o;
        @(posedge clk);
        @(posedge clk);
        #1 rvalid = 1'b1;
        @(posedge clk);
        #1 rvalid = 1'b0;
      end
    end
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    stb = 1'b1; cyc = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
  endtask

  task automatic wb_wait(input string tag, output logic [31:0] rd);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wbs_ack_o && n < 60);
    chk(tag, {31'b0, wbs_ack_o}, 32'd1);
    rd = wbs_dat_o;
    stb = 1'b0; cyc = 1'b0; we_i = 1'b0;
  endtask

  task automatic wb_wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    logic [31:0] dummy;
    wb_start(1'b1, adr, dat, sel);
    wb_wait(tag, dummy);
  endtask

  task automatic wb_rd(input string tag, input logic [31:0] adr, output logic [31:0] rd);
    wb_start(1'b0, adr, 32'h0, 4'hF);
    wb_wait(tag, rd);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdv;
    logic        saw_ack;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {31'b0, core_hold_o}, 32'd1);
    chk("rst_crst", {31'b0, core_rst_o}, 32'd1);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    rst = 1'b0;
    cyc_wait(1);
    wb_rd("status_rst_ack", A_STATUS, rdv);  chk("status_rst", rdv, 32'h20);
    wb_rd("addr_rst_ack", A_ADDR, rdv);      chk("addr_rst", rdv, 32'h0);
    wb_rd("ctrl_rst_ack", A_CTRL, rdv);      chk("ctrl_rst", rdv, 32'h3);

    // Release the core, read PC, unmapped and out-of-window accesses
    wb_wr("ctrl_wr_ack", A_CTRL, 32'h0, 4'hF);
    chk("hold_clr", {31'b0, core_hold_o}, 32'd0);
    chk("crst_clr", {31'b0, core_rst_o}, 32'd0);
    pc = 32'h1234_5678;
    wb_rd("pc_ack", A_PC, rdv);              chk("pc", rdv, 32'h1234_5678);
    wb_rd("unmap_ack", 32'h3000_0014, rdv);  chk("unmapped", rdv, 32'h0);
    wb_wr("outwin_wr_ack", 32'h3000_0100, 32'h3, 4'hF);
    wb_rd("ctrl_after_outwin_ack", A_CTRL, rdv);  chk("ctrl_after_outwin", rdv, 32'h0);
`ifndef IBN_WB_READBACK_EN
    wb_rd("data_rd_ack", A_DATA, rdv);       chk("data_rd_zero", rdv, 32'h0);
`endif

    // Write sequence with wrap-around, gnt always high
    gnt = 1'b1;
    wb_wr("addr_wr_ack", A_ADDR, 32'h3FE, 4'hF);
    wb_wr("data_a_ack", A_DATA, 32'hA, 4'hF);
    wb_wr("data_b_ack", A_DATA, 32'hB, 4'hF);
    wb_wr("data_c_ack", A_DATA, 32'hC, 4'hF);
    cyc_wait(8);
    chk("seq_count", wr_cnt, 32'd3);
    chk("seq_addr0", {22'b0, wr_addr[0]}, 32'h3FE);
    chk("seq_data0", wr_data[0], 32'hA);
    chk("seq_addr1", {22'b0, wr_addr[1]}, 32'h3FF);
    chk("seq_data1", wr_data[1], 32'hB);
    chk("seq_addr2", {22'b0, wr_addr[2]}, 32'h000);
    chk("seq_data2", wr_data[2], 32'hC);
    wb_rd("addr_wrap_ack", A_ADDR, rdv);     chk("addr_wrap", rdv, 32'h1);

    // Full buffer: 4 writes fill it, the 5th stalls until one grant
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) wb_wr("fill_ack", A_DATA, 32'h100 + i, 4'hF);
    cyc_wait(2);
    wb_rd("status_full_ack", A_STATUS, rdv); chk("status_full", rdv, 32'h14);
    wb_start(1'b1, A_DATA, 32'h104, 4'hF);
    saw_ack = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      saw_ack = saw_ack | wbs_ack_o;
    end
    chk("stall_no_ack", {31'b0, saw_ack}, 32'd0);
    chk("stall_no_write", wr_cnt, 32'd3);
    gnt = 1'b1;
    @(posedge clk);
    #1;
    gnt = 1'b0;
    wb_wait("stall_release_ack", rdv);
    chk("stall_one_write", wr_cnt, 32'd4);
    gnt = 1'b1;
    cyc_wait(14);
    chk("full_count", wr_cnt, 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("full_addr", {22'b0, wr_addr[3+i]}, 32'(1 + i));
      chk("full_data", wr_data[3+i], 32'h100 + i);
    end
    wb_rd("addr_after_full_ack", A_ADDR, rdv);  chk("addr_after_full", rdv, 32'h6);

    // Partial select on DATA: acked, dropped, sticky err, then cleared
    wb_wr("partial_ack", A_DATA, 32'hDEAD, 4'h3);
    cyc_wait(4);
    chk("partial_no_write", wr_cnt, 32'd8);
    wb_rd("status_err_ack", A_STATUS, rdv);  chk("status_err", rdv, 32'h100);
    wb_wr("err_clr_ack", A_STATUS, 32'h100, 4'hF);
    wb_rd("status_clr_ack", A_STATUS, rdv);  chk("status_err_clr", rdv, 32'h0);
    wb_rd("addr_partial_ack", A_ADDR, rdv);  chk("addr_partial", rdv, 32'h6);

    // Reset while three entries are pending
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) wb_wr("pend_ack", A_DATA, 32'h200 + i, 4'hF);
    cyc_wait(2);
    chk("pend_req", {31'b0, imem_req_o}, 32'd1);
    wb_rd("status_pend_ack", A_STATUS, rdv); chk("status_pend", rdv, 32'h13);
    rst = 1'b1;
    #1;
    chk("rst_req_drop", {31'b0, imem_req_o}, 32'd0);
    chk("rst_hold_again", {31'b0, core_hold_o}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    gnt = 1'b1;
    cyc_wait(10);
    chk("rst_no_write", wr_cnt, 32'd8);
    wb_rd("status_post_rst_ack", A_STATUS, rdv);  chk("status_post_rst", rdv, 32'h20);
    wb_rd("addr_post_rst_ack", A_ADDR, rdv);      chk("addr_post_rst", rdv, 32'h0);

`ifdef IBN_WB_READBACK_EN
    // Read-back: two pending writes drain before the read at ADDR=5
    gnt = 1'b0;
    rdata = 32'hCAFE_F00D;
    wb_wr("rb_addr_ack", A_ADDR, 32'h3, 4'hF);
    wb_wr("rb_w0_ack", A_DATA, 32'h11, 4'hF);
    wb_wr("rb_w1_ack", A_DATA, 32'h22, 4'hF);
    wb_start(1'b0, A_DATA, 32'h0, 4'hF);
    cyc_wait(3);
    chk("rb_no_early_read", rd_cnt, 32'd0);
    gnt = 1'b1;
    wb_wait("rb_ack", rdv);
    chk("rb_rdata", rdv, 32'hCAFE_F00D);
    chk("rb_wr_count", wr_cnt, 32'd10);
    chk("rb_wr_addr0", {22'b0, wr_addr[8]}, 32'h3);
    chk("rb_wr_addr1", {22'b0, wr_addr[9]}, 32'h4);
    chk("rb_rd_addr", {22'b0, rd_addr_seen}, 32'h5);
    chk("rb_rd_after_writes", rd_after, 32'd10);
    wb_rd("rb_addr_post_ack", A_ADDR, rdv);  chk("rb_addr_post", rdv, 32'h6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
